// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock-divider controller.
// Holds the FSM state encoding and the divisor clamp used on incoming configuration.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int unsigned MinDivisor = 2;

    // Divisors of 0 and 1 cannot form a period with both a high and a low phase.
    function automatic int unsigned clamp_divisor(input int unsigned d);
        return (d < MinDivisor) ? MinDivisor : d;
    endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Period counter with registered clk_out/tick generation.
// i_divisor is the divisor that applies in the cycle being registered.
module clkdiv_core #(
    parameter int Width = 8
) (
    input  logic             i_clk,
    input  logic             i_run,
    input  logic             i_load_zero,
    input  logic [Width-1:0] i_divisor,
    output logic             o_cnt_last,
    output logic             o_clk_out,
    output logic             o_tick
);

    logic [Width-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;

    logic [Width-1:0] w_cnt_nxt;
    logic [Width:0]   w_half;
    logic [Width-1:0] w_last;

    always_comb begin
        w_half = ({1'b0, i_divisor} + (Width+1)'(1)) >> 1;
        w_last = i_divisor - Width'(1);
        // The registered tick marks cnt == D-1, so it doubles as the wrap condition.
        if (i_load_zero || !i_run || r_tick) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + Width'(1);
        end
    end

    // Output register stage: clk_out and tick are aligned with cnt.
    always_ff @(posedge i_clk) begin
        r_cnt     <= w_cnt_nxt;
        r_clk_out <= i_run && ({1'b0, w_cnt_nxt} < w_half);
        r_tick    <= i_run && (w_cnt_nxt == w_last);
    end

    assign o_cnt_last = r_tick;
    assign o_clk_out  = r_clk_out;
    assign o_tick     = r_tick;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time controller for the clock divider: FSM, config staging and burst counting.
// New configuration only takes effect at a period boundary so clk_out never glitches.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int Width          = 8,
    parameter int DefaultDivisor = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [Width-1:0] i_cfg_divisor,
    input  logic [Width-1:0] i_cfg_burst,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    logic [Width-1:0] r_div;
    logic [Width-1:0] r_burst;
    logic [Width-1:0] r_stg_div;
    logic [Width-1:0] r_stg_burst;
    logic             r_stg_pend;
    logic [Width-1:0] r_bcnt;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;

    state_t           w_state_nxt;
    logic [Width-1:0] w_div_nxt;
    logic [Width-1:0] w_burst_nxt;
    logic [Width-1:0] w_bcnt_nxt;
    logic [Width-1:0] w_cfg_div;
    logic             w_pend_nxt;
    logic             w_acc;
    logic             w_active;
    logic             w_bnd;
    logic             w_burst_end;
    logic             w_stage;
    logic             w_run;
    logic             w_load_zero;
    logic             w_cnt_last;

    always_comb begin
        w_acc       = i_cfg_valid && r_ready;
        w_active    = (r_state == RUN) || (r_state == STOP);
        w_bnd       = w_active && w_cnt_last;
        w_burst_end = w_bnd && (r_bcnt == Width'(1));
        w_cfg_div   = Width'(clamp_divisor(32'(i_cfg_divisor)));

        w_div_nxt   = r_div;
        w_burst_nxt = r_burst;
        w_pend_nxt  = r_stg_pend;
        w_stage     = 1'b0;
        if (w_acc && ((r_state == IDLE) || w_bnd)) begin
            w_div_nxt   = w_cfg_div;
            w_burst_nxt = i_cfg_burst;
        end else if (w_bnd && r_stg_pend) begin
            w_div_nxt   = r_stg_div;
            w_burst_nxt = r_stg_burst;
            w_pend_nxt  = 1'b0;
        end else if (w_acc) begin
            w_stage    = 1'b1;
            w_pend_nxt = 1'b1;
        end

        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (i_enable) w_state_nxt = RUN;
            RUN: begin
                if (w_burst_end)    w_state_nxt = HOLD;
                else if (!i_enable) w_state_nxt = STOP;
            end
            STOP: begin
                // A burst finishing during STOP still reports done via HOLD.
                if (w_burst_end)   w_state_nxt = HOLD;
                else if (i_enable) w_state_nxt = RUN;
                else if (w_bnd)    w_state_nxt = IDLE;
            end
            HOLD: if (!i_enable) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        w_bcnt_nxt = r_bcnt;
        if ((r_state == IDLE) && i_enable) begin
            w_bcnt_nxt = w_burst_nxt;
        end else if (w_bnd && (r_bcnt != '0)) begin
            w_bcnt_nxt = r_bcnt - Width'(1);
        end

        w_run       = !i_rst && ((w_state_nxt == RUN) || (w_state_nxt == STOP));
        w_load_zero = i_rst || (r_state == IDLE) || (r_state == HOLD);
    end

    // Control register stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_div      <= Width'(DefaultDivisor);
            r_burst    <= '0;
            r_stg_pend <= 1'b0;
            r_bcnt     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_burst    <= w_burst_nxt;
            r_stg_pend <= w_pend_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_busy     <= w_run;
            r_done     <= w_burst_end;
            r_ready    <= !w_pend_nxt && (w_state_nxt != HOLD);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_stage) begin
            r_stg_div   <= w_cfg_div;
            r_stg_burst <= i_cfg_burst;
        end
    end

    clkdiv_core #(
        .Width(Width)
    ) u_core (
        .i_clk       (i_clk),
        .i_run       (w_run),
        .i_load_zero (w_load_zero),
        .i_divisor   (w_div_nxt),
        .o_cnt_last  (w_cnt_last),
        .o_clk_out   (o_clk_out),
        .o_tick      (o_tick)
    );

    assign o_cfg_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: per-cycle expected outputs queued with stimulus.
// Output vector order is {clk_out, tick, busy, done, cfg_ready}.
module tb_clkdiv_ctrl;

    localparam logic [4:0] E_IDLE      = 5'b00001;
    localparam logic [4:0] E_HOLD_DONE = 5'b00010;
    localparam logic [4:0] E_HOLD      = 5'b00000;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_divisor;
    logic [7:0] cfg_burst;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       done;

    typedef struct {
        string      tag;
        logic [4:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    clkdiv_ctrl #(
        .Width(8),
        .DefaultDivisor(4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_cfg_valid   (cfg_valid),
        .o_cfg_ready   (cfg_ready),
        .i_cfg_divisor (cfg_divisor),
        .i_cfg_burst   (cfg_burst),
        .o_clk_out     (clk_out),
        .o_tick        (tick),
        .o_busy        (busy),
        .o_done        (done)
    );

    task automatic check_vec(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b (clk_out,tick,busy,done,cfg_ready) t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] e_run(input int c, input int d, input logic rdy);
        logic hi;
        logic tk;
        hi = (c < (d + 1) / 2);
        tk = (c == d - 1);
        return {hi, tk, 1'b1, 1'b0, rdy};
    endfunction

    // Inputs are already set by the caller; one clock later the DUT output is compared.
    task automatic step(input string tag, input logic [4:0] e);
        exp_t x;
        x.tag = tag;
        x.v   = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_vec({tag, "_sb_empty"}, 5'bxxxxx, e);
        end else begin
            x = exp_q.pop_front();
            check_vec(x.tag, {clk_out, tick, busy, done, cfg_ready}, x.v);
        end
    endtask

    task automatic run_seq(input string tag, input int n, input int d, input int c0);
        for (int i = 0; i < n; i++) begin
            step(tag, e_run((c0 + i) % d, d, 1'b1));
        end
    endtask

    task automatic load_cfg(input string tag, input logic [7:0] div, input logic [7:0] bst);
        cfg_valid   = 1'b1;
        cfg_divisor = div;
        cfg_burst   = bst;
        step(tag, E_IDLE);
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] t5_div [2];
        t5_div[0] = 8'd0;
        t5_div[1] = 8'd1;

        rst         = 1'b1;
        enable      = 1'b0;
        cfg_valid   = 1'b0;
        cfg_divisor = 8'd0;
        cfg_burst   = 8'd0;
        step("reset", E_IDLE);
        rst = 1'b0;
        step("idle", E_IDLE);

        // Default divisor free-run: 1,1,0,0 with tick on the second low cycle.
        enable = 1'b1;
        run_seq("t1_d4", 12, 4, 0);

        // Mid-period reconfiguration to D=5, staged until the boundary.
        run_seq("t2_pre", 2, 4, 0);
        cfg_valid   = 1'b1;
        cfg_divisor = 8'd5;
        cfg_burst   = 8'd0;
        step("t2_acc", e_run(2, 4, 1'b0));
        cfg_valid = 1'b0;
        step("t2_tail", e_run(3, 4, 1'b0));
        run_seq("t2_d5", 13, 5, 0);
        enable = 1'b0;
        run_seq("t2_stop", 2, 5, 3);
        step("t2_idle", E_IDLE);

        // Burst of three D=6 periods, then HOLD until enable falls.
        load_cfg("t3_cfg", 8'd6, 8'd3);
        enable = 1'b1;
        run_seq("t3_burst", 18, 6, 0);
        step("t3_done", E_HOLD_DONE);
        for (int i = 0; i < 3; i++) step("t3_hold", E_HOLD);
        enable = 1'b0;
        step("t3_idle", E_IDLE);

        // D=8 stop at cnt=2 finishes the period; second run resumes from STOP.
        load_cfg("t4_cfg", 8'd8, 8'd0);
        enable = 1'b1;
        run_seq("t4_a", 3, 8, 0);
        enable = 1'b0;
        run_seq("t4_stop", 5, 8, 3);
        step("t4_idle", E_IDLE);
        enable = 1'b1;
        run_seq("t4_b", 3, 8, 0);
        enable = 1'b0;
        run_seq("t4_gap", 3, 8, 3);
        enable = 1'b1;
        run_seq("t4_resume", 7, 8, 6);
        enable = 1'b0;
        run_seq("t4_stop2", 3, 8, 5);
        step("t4_idle2", E_IDLE);

        // Divisors 0 and 1 clamp to 2.
        for (int k = 0; k < 2; k++) begin
            load_cfg("t5_cfg", t5_div[k], 8'd0);
            enable = 1'b1;
            run_seq("t5_d2", 5, 2, 0);
            enable = 1'b0;
            run_seq("t5_stop", 1, 2, 1);
            step("t5_idle", E_IDLE);
        end

        // Reset mid-burst with a staged config pending.
        load_cfg("t6_cfg", 8'd6, 8'd4);
        enable = 1'b1;
        run_seq("t6_run", 2, 6, 0);
        cfg_valid   = 1'b1;
        cfg_divisor = 8'd3;
        cfg_burst   = 8'd0;
        step("t6_stage", e_run(2, 6, 1'b0));
        cfg_valid = 1'b0;
        step("t6_pend", e_run(3, 6, 1'b0));
        rst = 1'b1;
        step("t6_reset", E_IDLE);
        rst = 1'b0;
        run_seq("t6_default", 8, 4, 0);
        enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
